// File: rtl/marbuffer_pkg.sv
// Shared types for the timed output buffer: queue entry layout and replay FSM states.
package marbuffer_pkg;

  localparam int unsigned MB_DATA_W  = 16;
  localparam int unsigned MB_DELAY_W = 7;

  typedef struct packed {
    logic                  last;
    logic [MB_DELAY_W-1:0] delay;
    logic [MB_DATA_W-1:0]  data;
  } mb_entry_t;

  typedef enum logic {
    MB_IDLE,
    MB_ACTIVE
  } mb_state_e;

endpackage

// File: rtl/marbuffer_ext_if.sv
// Bus-side signal bundle of marbuffer_ext: decoder writes in, channel word and status out.
interface marbuffer_ext_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DELAY_W = 7,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0]  data_i;
  logic [DELAY_W-1:0] delay_i;
  logic               last_i;
  logic               valid_i;
  logic               direct_i;
  logic               flush_i;
  logic               clr_err_i;

  logic [DATA_W-1:0]  data_o;
  logic               stb_o;
  logic               empty_o;
  logic               full_o;
  logic               almost_full_o;
  logic [LVL_W-1:0]   level_o;
  logic               ovf_o;
  logic               udr_o;
  logic               ovf_sticky_o;
  logic               udr_sticky_o;

  modport master (
    output data_i, delay_i, last_i, valid_i, direct_i, flush_i, clr_err_i,
    input  data_o, stb_o, empty_o, full_o, almost_full_o, level_o,
           ovf_o, udr_o, ovf_sticky_o, udr_sticky_o
  );

  modport slave (
    input  data_i, delay_i, last_i, valid_i, direct_i, flush_i, clr_err_i,
    output data_o, stb_o, empty_o, full_o, almost_full_o, level_o,
           ovf_o, udr_o, ovf_sticky_o, udr_sticky_o
  );

endinterface

// File: rtl/marfifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module marfifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/marbuffer_ext.sv
// Timed output buffer: replays queued {data, delay, last} words, one pop per (delay+1) clocks,
// with direct bypass writes, flush, and overflow/underrun reporting.
module marbuffer_ext
  import marbuffer_pkg::*;
#(
  parameter int unsigned DATA_W       = MB_DATA_W,
  parameter int unsigned DELAY_W      = MB_DELAY_W,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = 3
) (
  input logic             clk,
  input logic             rst,
  marbuffer_ext_if.slave  bus
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic               last;
    logic [DELAY_W-1:0] delay;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t             wr_entry;
  entry_t             head;
  logic [LVL_W-1:0]   level;
  logic               fifo_full;
  logic               fifo_empty;

  mb_state_e          state;
  logic [DELAY_W-1:0] cnt;
  logic               cur_last;
  logic [DATA_W-1:0]  data_q;
  logic               stb_q;
  logic               ovf_q;
  logic               udr_q;
  logic               ovf_st;
  logic               udr_st;

  logic               cnt_zero;
  logic               push;
  logic               pop;
  logic               ovf_evt;
  logic               udr_evt;

  // Fullness is the pre-pop value, so a push into a full queue drops even if it pops now.
  always_comb begin
    wr_entry       = '0;
    wr_entry.last  = bus.last_i;
    wr_entry.delay = bus.delay_i;
    wr_entry.data  = bus.data_i;
    cnt_zero = (cnt == '0);
    push     = bus.valid_i & ~fifo_full & ~bus.flush_i;
    ovf_evt  = bus.valid_i & fifo_full & ~bus.flush_i;
    pop      = cnt_zero & ~fifo_empty & ~bus.direct_i & ~bus.flush_i;
    udr_evt  = (state == MB_ACTIVE) & cnt_zero & fifo_empty & ~cur_last & ~bus.flush_i;
  end

  marfifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush_i),
    .din   (wr_entry),
    .dout  (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MB_IDLE;
      cnt      <= '0;
      cur_last <= 1'b0;
      data_q   <= '0;
      stb_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
      ovf_st   <= 1'b0;
      udr_st   <= 1'b0;
    end else begin
      stb_q <= pop | bus.direct_i;
      ovf_q <= ovf_evt;
      udr_q <= udr_evt;

      if (bus.direct_i)  data_q <= bus.data_i;
      else if (pop)      data_q <= head.data;

      // A direct write only defers a due pop; a running delay keeps counting through it.
      if (bus.flush_i) begin
        cnt   <= '0;
        state <= MB_IDLE;
      end else if (pop) begin
        cnt      <= head.delay;
        cur_last <= head.last;
        state    <= MB_ACTIVE;
      end else begin
        if (!cnt_zero) cnt <= cnt - 1'b1;
        if (state == MB_ACTIVE && cnt_zero && fifo_empty) state <= MB_IDLE;
      end

      if (ovf_evt)            ovf_st <= 1'b1;
      else if (bus.clr_err_i) ovf_st <= 1'b0;
      if (udr_evt)            udr_st <= 1'b1;
      else if (bus.clr_err_i) udr_st <= 1'b0;
    end
  end

  assign bus.data_o        = data_q;
  assign bus.stb_o         = stb_q;
  assign bus.empty_o       = fifo_empty;
  assign bus.full_o        = fifo_full;
  assign bus.almost_full_o = (level >= LVL_W'(AFULL_THRESH));
  assign bus.level_o       = level;
  assign bus.ovf_o         = ovf_q;
  assign bus.udr_o         = udr_q;
  assign bus.ovf_sticky_o  = ovf_st;
  assign bus.udr_sticky_o  = udr_st;

endmodule

// File: tb/tb_marbuffer_ext.sv
// Scenario bench for marbuffer_ext: a strobe monitor checks data order against a scoreboard,
// each task checks timing, levels and flags of its own scenario.
module tb_marbuffer_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  marbuffer_ext_if #(.DATA_W(16), .DELAY_W(7), .DEPTH(4)) bus ();

  marbuffer_ext #(
    .DATA_W       (16),
    .DELAY_W      (7),
    .DEPTH        (4),
    .AFULL_THRESH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ovf_pulses = 0;
  logic [15:0] sb [$];
  int          stb_times [$];
  int          udr_times [$];
  logic [15:0] exp_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.stb_o === 1'b1) begin
      stb_times.push_back(cyc);
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stb_unexpected: data_o=%h at cycle %0d, required no strobe", bus.data_o, cyc);
      end else begin
        exp_d = sb.pop_front();
        if (bus.data_o !== exp_d) begin
          n_fail++;
          $display("FAIL stb_data: data_o=%h, required %h (cycle %0d)", bus.data_o, exp_d, cyc);
        end
      end
    end
    if (bus.udr_o === 1'b1) udr_times.push_back(cyc);
    if (bus.ovf_o === 1'b1) ovf_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_i    = '0;
    bus.delay_i   = '0;
    bus.last_i    = 1'b0;
    bus.valid_i   = 1'b0;
    bus.direct_i  = 1'b0;
    bus.flush_i   = 1'b0;
    bus.clr_err_i = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic [6:0] dl, input logic l, input bit accept);
    bus.data_i  = d;
    bus.delay_i = dl;
    bus.last_i  = l;
    bus.valid_i = 1'b1;
    if (accept) sb.push_back(d);
    tick();
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
  endtask

  task automatic wait_stb(input int n, input int budget);
    int b;
    b = budget;
    while (stb_times.size() < n && b > 0) begin
      tick();
      b--;
    end
  endtask

  task automatic clear_err();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h, want 0000", bus.data_o); end
    n_checks++; if (bus.stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b, want 0", bus.stb_o); end
    n_checks++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, want 1", bus.empty_o); end
    n_checks++; if (bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got full=%b afull=%b, want 0 0", bus.full_o, bus.almost_full_o); end
    n_checks++; if (bus.level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, want 0", bus.level_o); end
    n_checks++; if ({bus.ovf_o, bus.udr_o, bus.ovf_sticky_o, bus.udr_sticky_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b, want 0000", {bus.ovf_o, bus.udr_o, bus.ovf_sticky_o, bus.udr_sticky_o}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int t0;
    stb_times.delete();
    udr_times.delete();
    t0 = cyc;
    push(16'h0001, 7'd0, 1'b1, 1'b1);
    wait_stb(1, 10);
    repeat (3) tick();
    n_checks++; if (stb_times.size() != 1 || stb_times[0] != t0 + 2) begin n_fail++; $display("FAIL latency: strobes=%0d first=%0d, want 1 at %0d", stb_times.size(), (stb_times.size() > 0) ? stb_times[0] - t0 : -1, 2); end
    n_checks++; if (bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL latency_empty: got %b, want 1", bus.empty_o); end
    n_checks++; if (udr_times.size() != 0) begin n_fail++; $display("FAIL latency_udr: got %0d pulses, want 0", udr_times.size()); end
  endtask

  task automatic test_back_to_back();
    int ovf0;
    stb_times.delete();
    ovf0 = ovf_pulses;
    for (int i = 1; i <= 8; i++) push(16'(i), 7'd0, (i == 8), 1'b1);
    wait_stb(8, 20);
    repeat (3) tick();
    n_checks++; if (stb_times.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d, want 8", stb_times.size()); end
    for (int i = 1; i < 8 && i < stb_times.size(); i++) begin
      n_checks++; if (stb_times[i] - stb_times[i-1] != 1) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d, want 1", i, stb_times[i] - stb_times[i-1]); end
    end
    n_checks++; if (ovf_pulses != ovf0) begin n_fail++; $display("FAIL b2b_ovf: got %0d pulses, want 0", ovf_pulses - ovf0); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_overflow();
    int ovf0;
    stb_times.delete();
    ovf0 = ovf_pulses;
    for (int i = 1; i <= 7; i++) push(16'h0100 + 16'(i), 7'd1, (i == 7), 1'b1);
    n_checks++; if (bus.level_o !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d, want 4", bus.level_o); end
    n_checks++; if (bus.full_o !== 1'b1 || bus.almost_full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got full=%b afull=%b, want 1 1", bus.full_o, bus.almost_full_o); end
    push(16'h0108, 7'd1, 1'b0, 1'b0);
    n_checks++; if (bus.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b, want 1", bus.ovf_o); end
    tick();
    n_checks++; if (bus.ovf_o !== 1'b0 || bus.ovf_sticky_o !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got ovf=%b sticky=%b, want 0 1", bus.ovf_o, bus.ovf_sticky_o); end
    wait_stb(7, 40);
    repeat (3) tick();
    n_checks++; if (stb_times.size() != 7) begin n_fail++; $display("FAIL ovf_count: got %0d strobes, want 7", stb_times.size()); end
    for (int i = 1; i < 7 && i < stb_times.size(); i++) begin
      n_checks++; if (stb_times[i] - stb_times[i-1] != 2) begin n_fail++; $display("FAIL ovf_spacing[%0d]: got %0d, want 2", i, stb_times[i] - stb_times[i-1]); end
    end
    n_checks++; if (ovf_pulses - ovf0 != 1 || bus.ovf_sticky_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_hold: got pulses=%0d sticky=%b, want 1 1", ovf_pulses - ovf0, bus.ovf_sticky_o); end
    clear_err();
    n_checks++; if (bus.ovf_sticky_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, want 0", bus.ovf_sticky_o); end
  endtask

  task automatic test_underrun();
    stb_times.delete();
    udr_times.delete();
    push(16'h1111, 7'd2, 1'b0, 1'b1);
    tick();
    tick();
    push(16'h2222, 7'd0, 1'b0, 1'b1);
    wait_stb(2, 20);
    repeat (4) tick();
    n_checks++; if (stb_times.size() != 2 || stb_times[1] - stb_times[0] != 3) begin n_fail++; $display("FAIL udr_spacing: got %0d strobes gap %0d, want 2 gap 3", stb_times.size(), (stb_times.size() > 1) ? stb_times[1] - stb_times[0] : -1); end
    n_checks++; if (udr_times.size() != 1 || stb_times.size() < 2 || udr_times[0] != stb_times[1] + 1) begin n_fail++; $display("FAIL udr_pulse: got %0d pulses at %0d, want 1 at 0x2222 strobe+1", udr_times.size(), (udr_times.size() > 0) ? udr_times[0] : -1); end
    n_checks++; if (bus.udr_sticky_o !== 1'b1) begin n_fail++; $display("FAIL udr_sticky: got %b, want 1", bus.udr_sticky_o); end
    clear_err();
    n_checks++; if (bus.udr_sticky_o !== 1'b0) begin n_fail++; $display("FAIL udr_clear: got %b, want 0", bus.udr_sticky_o); end
  endtask

  task automatic test_direct();
    int t0;
    int want [4];
    stb_times.delete();
    udr_times.delete();
    t0 = cyc;
    push(16'hA001, 7'd5, 1'b0, 1'b1);
    push(16'hA002, 7'd5, 1'b0, 1'b1);
    push(16'hA003, 7'd5, 1'b1, 1'b1);
    tick();
    bus.data_i   = 16'h04D2;
    bus.direct_i = 1'b1;
    sb.push_front(16'h04D2);
    tick();
    bus.direct_i = 1'b0;
    wait_stb(4, 40);
    repeat (3) tick();
    want = '{t0 + 2, t0 + 5, t0 + 8, t0 + 14};
    n_checks++; if (stb_times.size() != 4) begin n_fail++; $display("FAIL direct_count: got %0d strobes, want 4", stb_times.size()); end
    for (int i = 0; i < 4 && i < stb_times.size(); i++) begin
      n_checks++; if (stb_times[i] != want[i]) begin n_fail++; $display("FAIL direct_time[%0d]: got %0d, want %0d", i, stb_times[i] - t0, want[i] - t0); end
    end
    n_checks++; if (udr_times.size() != 0) begin n_fail++; $display("FAIL direct_udr: got %0d pulses, want 0", udr_times.size()); end
  endtask

  task automatic test_flush_reset();
    int ovf0;
    stb_times.delete();
    udr_times.delete();
    ovf0 = ovf_pulses;
    for (int i = 1; i <= 4; i++) push(16'hB000 + 16'(i), 7'd10, 1'b0, 1'b1);
    wait_stb(1, 10);
    bus.flush_i = 1'b1;
    sb.delete();
    tick();
    bus.flush_i = 1'b0;
    repeat (30) tick();
    n_checks++; if (stb_times.size() != 1) begin n_fail++; $display("FAIL flush_strobes: got %0d, want 1", stb_times.size()); end
    n_checks++; if (bus.level_o !== 3'd0 || bus.empty_o !== 1'b1) begin n_fail++; $display("FAIL flush_level: got level=%0d empty=%b, want 0 1", bus.level_o, bus.empty_o); end
    n_checks++; if (bus.data_o !== 16'hB001) begin n_fail++; $display("FAIL flush_hold: got %h, want b001", bus.data_o); end
    n_checks++; if (udr_times.size() != 0 || ovf_pulses != ovf0) begin n_fail++; $display("FAIL flush_err: got udr=%0d ovf=%0d, want 0 0", udr_times.size(), ovf_pulses - ovf0); end

    stb_times.delete();
    push(16'hC001, 7'd3, 1'b0, 1'b1);
    push(16'hC002, 7'd3, 1'b0, 1'b1);
    wait_stb(1, 10);
    rst = 1'b1;
    sb.delete();
    tick();
    n_checks++; if (bus.data_o !== 16'h0000 || bus.stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got data=%h stb=%b, want 0000 0", bus.data_o, bus.stb_o); end
    n_checks++; if (bus.level_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_level: got level=%0d empty=%b full=%b, want 0 1 0", bus.level_o, bus.empty_o, bus.full_o); end
    n_checks++; if ({bus.ovf_sticky_o, bus.udr_sticky_o} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags: got %b, want 00", {bus.ovf_sticky_o, bus.udr_sticky_o}); end
    rst = 1'b0;
    repeat (10) tick();
    n_checks++; if (stb_times.size() != 1 || udr_times.size() != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got strobes=%0d udr=%0d, want 1 0", stb_times.size(), udr_times.size()); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_underrun();
    test_direct();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
